// File: rtl/amm_trans_engine.sv
// amm_trans_engine: turns accepted write/read op packets into single Avalon-MM bursts
module amm_trans_engine #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int AMM_BURST_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   op_valid_i,
    input  logic                   op_pkt_type_i,
    input  logic [ADDR_W-1:0]      op_word_addr_i,
    output logic                   cmd_accept_ready_o,
    input  logic [AMM_BURST_W-1:0] burstcount_i,
    input  logic [7:0]             data_pattern_i,
    output logic [ADDR_W-1:0]      amm_address_o,
    output logic [AMM_BURST_W-1:0] amm_burstcount_o,
    output logic                   amm_write_o,
    output logic [DATA_W-1:0]      amm_writedata_o,
    output logic [DATA_W/8-1:0]    amm_byteenable_o,
    output logic                   amm_read_o,
    input  logic                   amm_waitrequest_i,
    input  logic                   amm_readdatavalid_i,
    input  logic [DATA_W-1:0]      amm_readdata_i,
    output logic                   rd_data_valid_o,
    output logic [DATA_W-1:0]      rd_data_o,
    output logic                   unexp_rd_o,
    output logic                   busy_o
);
    typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_DATA} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [AMM_BURST_W-1:0] bc_q, bc_d, beat_q, beat_d, rem_q, rem_d;
    logic [7:0]             seed_q, seed_d;
    logic                   rd_valid_q, rd_valid_d, unexp_q, unexp_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic [7:0]             wr_byte;

    // Next-state, burst bookkeeping and read-beat capture
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        bc_d       = bc_q;
        seed_d     = seed_q;
        beat_d     = beat_q;
        rem_d      = rem_q;
        case (state_q)
            IDLE: if (op_valid_i) begin
                addr_d  = op_word_addr_i;
                bc_d    = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;
                seed_d  = data_pattern_i;
                beat_d  = '0;
                state_d = op_pkt_type_i ? RD_CMD : WR_BURST;
            end
            WR_BURST: if (!amm_waitrequest_i) begin
                if (beat_q == bc_q - AMM_BURST_W'(1)) state_d = IDLE;
                else beat_d = beat_q + AMM_BURST_W'(1);
            end
            RD_CMD: if (!amm_waitrequest_i) begin
                rem_d   = bc_q;
                state_d = RD_DATA;
            end
            RD_DATA: if (amm_readdatavalid_i) begin
                rem_d = rem_q - AMM_BURST_W'(1);
                if (rem_q == AMM_BURST_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rd_valid_d = amm_readdatavalid_i && (state_q == RD_DATA);
        unexp_d    = amm_readdatavalid_i && (state_q != RD_DATA);
        rd_data_d  = rd_valid_d ? amm_readdata_i : rd_data_q;
    end

    // State and datapath registers; reset abandons any burst in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            bc_q       <= '0;
            seed_q     <= '0;
            beat_q     <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            unexp_q    <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            bc_q       <= bc_d;
            seed_q     <= seed_d;
            beat_q     <= beat_d;
            rem_q      <= rem_d;
            rd_valid_q <= rd_valid_d;
            unexp_q    <= unexp_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign wr_byte            = seed_q ^ 8'(beat_q);
    assign cmd_accept_ready_o = (state_q == IDLE);
    assign amm_write_o        = (state_q == WR_BURST);
    assign amm_read_o         = (state_q == RD_CMD);
    assign amm_address_o      = addr_q;
    assign amm_burstcount_o   = bc_q;
    assign amm_writedata_o    = amm_write_o ? {(DATA_W/8){wr_byte}} : '0;
    assign amm_byteenable_o   = amm_write_o ? '1 : '0;
    assign rd_data_valid_o    = rd_valid_q;
    assign rd_data_o          = rd_data_q;
    assign unexp_rd_o         = unexp_q;
    assign busy_o             = (state_q != IDLE) || rd_valid_q;
endmodule
